// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: reaction-timer game sequencer on board_clk.
// Optional best-time tracking enabled by defining REACTION_BEST_EN.
module reaction_timer_ctrl #(
  parameter int SYS_CLK_HZ   = 50000000,
  parameter int TICK_HZ      = 1000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  parameter int MAX_MS       = 9999,
  parameter int CNT_W        = 14
) (
  input  logic             board_clk,
  input  logic             reset_n,
  input  logic             start_btn,
  input  logic             react_btn,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] time_ms,
  output logic             result_valid,
  output logic             false_start,
`ifdef REACTION_BEST_EN
  output logic [CNT_W-1:0] best_ms,
`endif
  output logic [1:0]       state_o
);

  localparam int TPM = SYS_CLK_HZ / TICK_HZ;
  localparam int PW  = (TPM > 1) ? $clog2(TPM) : 1;

  // Maximal-length tap masks, bit k = stage k+1.
  function automatic logic [15:0] taps(input int w);
    logic [15:0] m;
    m = 16'h0006;
    case (w)
      2:  m = 16'h0003;
      3:  m = 16'h0006;
      4:  m = 16'h000C;
      5:  m = 16'h0014;
      6:  m = 16'h0030;
      7:  m = 16'h0060;
      8:  m = 16'h00B8;
      9:  m = 16'h0110;
      10: m = 16'h0240;
      11: m = 16'h0500;
      12: m = 16'h0829;
      13: m = 16'h100D;
      14: m = 16'h2015;
      15: m = 16'h6000;
      16: m = 16'hD008;
      default: m = 16'h0006;
    endcase
    return m;
  endfunction

  localparam logic [15:0] TAP_ALL = taps(RAND_BITS);
  localparam logic [RAND_BITS-1:0] TAP =
    TAP_ALL[RAND_BITS-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_LIGHT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [CNT_W-1:0]     delay_q, delay_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     time_d;
  logic                 rv_d, fs_d;
  logic [RAND_BITS-1:0] lfsr_q;
  logic                 start_q, react_q, hist_vld;
  logic                 start_edge, react_edge;
  logic                 tick;
`ifdef REACTION_BEST_EN
  logic [CNT_W-1:0]     best_d;
`endif

  assign tick    = (presc_q == PW'(TPM - 1));
  assign busy    = (state_q == S_WAIT) ||
                   (state_q == S_LIGHT);
  assign state_o = state_q;

  // Registered edge detect; hist_vld masks a button held through reset.
  always_ff @(posedge board_clk) begin
    if (!reset_n) begin
      start_q    <= 1'b0;
      react_q    <= 1'b0;
      hist_vld   <= 1'b0;
      start_edge <= 1'b0;
      react_edge <= 1'b0;
    end else begin
      start_q    <= start_btn;
      react_q    <= react_btn;
      hist_vld   <= 1'b1;
      start_edge <= start_btn & ~start_q & hist_vld;
      react_edge <= react_btn & ~react_q & hist_vld;
    end
  end

  // Free-running Fibonacci LFSR, never zero.
  always_ff @(posedge board_clk) begin
    if (!reset_n) begin
      lfsr_q <= '1;
    end else begin
      lfsr_q <= {lfsr_q[RAND_BITS-2:0], ^(lfsr_q & TAP)};
    end
  end

  // Next-state and datapath updates for the round sequencer.
  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    delay_d = delay_q;
    count_d = count_q;
    time_d  = time_ms;
    rv_d    = 1'b0;
    fs_d    = false_start;
`ifdef REACTION_BEST_EN
    best_d  = best_ms;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_WAIT;
          delay_d = CNT_W'(MIN_DELAY_MS) + CNT_W'(lfsr_q);
          fs_d    = 1'b0;
          presc_d = '0;
        end
      end
      S_WAIT: begin
        if (react_edge) begin
          fs_d    = 1'b1;
          state_d = S_IDLE;
        end else if (tick) begin
          delay_d = delay_q - 1'b1;
          if (delay_q == CNT_W'(1)) begin
            state_d = S_LIGHT;
            count_d = '0;
            presc_d = '0;
          end
        end
      end
      S_LIGHT: begin
        if (react_edge) begin
          time_d  = count_q;
          rv_d    = 1'b1;
          state_d = S_DONE;
`ifdef REACTION_BEST_EN
          if (count_q < best_ms) best_d = count_q;
`endif
        end else if (tick && count_q != CNT_W'(MAX_MS)) begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; led trails the state by one cycle.
  always_ff @(posedge board_clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      delay_q      <= '0;
      count_q      <= '0;
      time_ms      <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      led          <= 1'b0;
`ifdef REACTION_BEST_EN
      best_ms      <= CNT_W'(MAX_MS);
`endif
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      delay_q      <= delay_d;
      count_q      <= count_d;
      time_ms      <= time_d;
      result_valid <= rv_d;
      false_start  <= fs_d;
      led          <= (state_q == S_LIGHT);
`ifdef REACTION_BEST_EN
      best_ms      <= best_d;
`endif
    end
  end

endmodule
